// File: rtl/mux_4x1_nbit_if.sv
// Bundle for the 4-input word selector: capture strobe, select, four data
// words in; registered word, valid flag, latched select and change pulse out.
interface mux_4x1_nbit_if #(
    parameter int n = 4
) ();
    logic           en;
    logic [n-1:0]   A;
    logic [n-1:0]   B;
    logic [n-1:0]   C;
    logic [n-1:0]   D;
    logic [1:0]     S;
    logic [n-1:0]   Y;
    logic           Y_valid;
    logic [1:0]     S_q;
    logic           Y_changed;

    modport master (
        output en, A, B, C, D, S,
        input  Y, Y_valid, S_q, Y_changed
    );

    modport slave (
        input  en, A, B, C, D, S,
        output Y, Y_valid, S_q, Y_changed
    );
endinterface

// File: rtl/mux_4x1_nbit.sv
// n-bit 4:1 word selector with a one-cycle registered output, a valid flag,
// the latched select code and a one-cycle pulse when a capture changes Y.
module mux_4x1_nbit #(
    parameter int n = 4
) (
    input  logic          clk,
    input  logic          rst,
    mux_4x1_nbit_if.slave bus
);
    logic [n-1:0] sel_d;
    logic [n-1:0] y_q;
    logic [n-1:0] y_d;
    logic         valid_q;
    logic         valid_d;
    logic [1:0]   s_q;
    logic [1:0]   s_d;
    logic         changed_q;
    logic         changed_d;

    always_comb begin
        sel_d = bus.D;
        unique case (bus.S)
            2'b00:   sel_d = bus.A;
            2'b01:   sel_d = bus.B;
            2'b10:   sel_d = bus.C;
            default: sel_d = bus.D;
        endcase
    end

    // The first capture after reset always pulses, even when the word equals
    // the cleared register contents.
    always_comb begin
        y_d       = y_q;
        valid_d   = valid_q;
        s_d       = s_q;
        changed_d = 1'b0;
        if (bus.en) begin
            y_d       = sel_d;
            valid_d   = 1'b1;
            s_d       = bus.S;
            changed_d = (sel_d != y_q) || !valid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q       <= '0;
            valid_q   <= 1'b0;
            s_q       <= 2'b00;
            changed_q <= 1'b0;
        end else begin
            y_q       <= y_d;
            valid_q   <= valid_d;
            s_q       <= s_d;
            changed_q <= changed_d;
        end
    end

    assign bus.Y         = y_q;
    assign bus.Y_valid   = valid_q;
    assign bus.S_q       = s_q;
    assign bus.Y_changed = changed_q;
endmodule

// File: tb/tb_mux_4x1_nbit.sv
// Bench for mux_4x1_nbit: directed vector table on an n=4 instance, then
// randomized traffic on n=4, n=16 and n=1 instances against a word-array model.
module tb_mux_4x1_nbit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_4x1_nbit_if #(.n(4))  if4  ();
    mux_4x1_nbit_if #(.n(16)) if16 ();
    mux_4x1_nbit_if #(.n(1))  if1  ();

    mux_4x1_nbit #(.n(4))  dut4  (.clk(clk), .rst(rst), .bus(if4.slave));
    mux_4x1_nbit #(.n(16)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
    mux_4x1_nbit #(.n(1))  dut1  (.clk(clk), .rst(rst), .bus(if1.slave));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] s;
        logic [3:0] a, b, c, d;
        logic [3:0] exp_y;
        logic       exp_v;
        logic [1:0] exp_s;
        logic       exp_c;
    } vec_t;

    vec_t vecs[$];

    // Model state: one entry per instance (0: n=4, 1: n=16, 2: n=1)
    logic [63:0] din  [3][4];
    logic        en_v [3];
    logic [1:0]  s_v  [3];
    logic [63:0] m_y  [3];
    logic        m_v  [3];
    logic [1:0]  m_s  [3];
    logic        m_c  [3];
    logic [63:0] masks[3];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic [1:0] s,
                       input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic [3:0] d, input logic [3:0] ey, input logic ev,
                       input logic [1:0] es, input logic ec);
        vec_t v;
        v = '{rst: r, en: e, s: s, a: a, b: b, c: c, d: d,
              exp_y: ey, exp_v: ev, exp_s: es, exp_c: ec};
        vecs.push_back(v);
    endtask

    // Drive all three instances from the din/en_v/s_v arrays, clock once,
    // advance the model and compare every output.
    task automatic apply_all(input logic r, input int txn);
        logic [63:0] sel;
        @(negedge clk);
        rst = r;
        if4.en  = en_v[0]; if4.S  = s_v[0];
        if4.A   = din[0][0][3:0];  if4.B  = din[0][1][3:0];
        if4.C   = din[0][2][3:0];  if4.D  = din[0][3][3:0];
        if16.en = en_v[1]; if16.S = s_v[1];
        if16.A  = din[1][0][15:0]; if16.B = din[1][1][15:0];
        if16.C  = din[1][2][15:0]; if16.D = din[1][3][15:0];
        if1.en  = en_v[2]; if1.S  = s_v[2];
        if1.A   = din[2][0][0];    if1.B  = din[2][1][0];
        if1.C   = din[2][2][0];    if1.D  = din[2][3][0];
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                m_y[k] = '0; m_v[k] = 1'b0; m_s[k] = 2'b00; m_c[k] = 1'b0;
            end else if (en_v[k]) begin
                sel    = din[k][s_v[k]] & masks[k];
                m_c[k] = (sel != m_y[k]) || !m_v[k];
                m_y[k] = sel;
                m_v[k] = 1'b1;
                m_s[k] = s_v[k];
            end else begin
                m_c[k] = 1'b0;
            end
        end
        #1;
        chk("n4.Y",          64'(if4.Y),          m_y[0]);
        chk("n4.Y_valid",    64'(if4.Y_valid),    64'(m_v[0]));
        chk("n4.S_q",        64'(if4.S_q),        64'(m_s[0]));
        chk("n4.Y_changed",  64'(if4.Y_changed),  64'(m_c[0]));
        chk("n16.Y",         64'(if16.Y),         m_y[1]);
        chk("n16.Y_valid",   64'(if16.Y_valid),   64'(m_v[1]));
        chk("n16.S_q",       64'(if16.S_q),       64'(m_s[1]));
        chk("n16.Y_changed", 64'(if16.Y_changed), 64'(m_c[1]));
        chk("n1.Y",          64'(if1.Y),          m_y[2]);
        chk("n1.Y_valid",    64'(if1.Y_valid),    64'(m_v[2]));
        chk("n1.S_q",        64'(if1.S_q),        64'(m_s[2]));
        chk("n1.Y_changed",  64'(if1.Y_changed),  64'(m_c[2]));
        $display("txn %0d rst=%0b n4:Y=%h n16:Y=%h n1:Y=%h", txn, r, if4.Y, if16.Y, if1.Y);
    endtask

    initial begin
        masks[0] = 64'hF; masks[1] = 64'hFFFF; masks[2] = 64'h1;
        rst = 1'b1;
        if4.en  = 1'b0; if4.S  = 2'b00; if4.A  = '0; if4.B  = '0; if4.C  = '0; if4.D  = '0;
        if16.en = 1'b0; if16.S = 2'b00; if16.A = '0; if16.B = '0; if16.C = '0; if16.D = '0;
        if1.en  = 1'b0; if1.S  = 2'b00; if1.A  = '0; if1.B  = '0; if1.C  = '0; if1.D  = '0;

        //    rst en  S      A        B        C        D        Y        v  S_q    chg
        add(1, 1, 2'd0, 4'hA, 4'h6, 4'hD, 4'h1, 4'h0, 0, 2'd0, 0);  // reset held
        add(1, 1, 2'd0, 4'hA, 4'h6, 4'hD, 4'h1, 4'h0, 0, 2'd0, 0);
        add(0, 1, 2'd0, 4'hA, 4'h6, 4'hD, 4'h1, 4'hA, 1, 2'd0, 1);  // select sweep
        add(0, 1, 2'd1, 4'hA, 4'h6, 4'hD, 4'h1, 4'h6, 1, 2'd1, 1);
        add(0, 1, 2'd2, 4'hA, 4'h6, 4'hD, 4'h1, 4'hD, 1, 2'd2, 1);
        add(0, 1, 2'd3, 4'hA, 4'h6, 4'hD, 4'h1, 4'h1, 1, 2'd3, 1);
        add(0, 1, 2'd2, 4'hA, 4'h6, 4'hD, 4'h1, 4'hD, 1, 2'd2, 1);
        add(0, 0, 2'd3, 4'hA, 4'h6, 4'h0, 4'h1, 4'hD, 1, 2'd2, 0);  // hold
        add(0, 0, 2'd3, 4'hA, 4'h6, 4'h0, 4'h1, 4'hD, 1, 2'd2, 0);
        add(0, 0, 2'd3, 4'hA, 4'h6, 4'h0, 4'h1, 4'hD, 1, 2'd2, 0);
        add(0, 1, 2'd1, 4'hA, 4'h6, 4'hD, 4'h1, 4'h6, 1, 2'd1, 1);  // repeated capture
        add(0, 1, 2'd1, 4'hA, 4'h6, 4'hD, 4'h1, 4'h6, 1, 2'd1, 0);
        add(0, 1, 2'd1, 4'hA, 4'h6, 4'hD, 4'h1, 4'h6, 1, 2'd1, 0);
        add(0, 1, 2'd3, 4'hA, 4'h6, 4'hD, 4'h1, 4'h1, 1, 2'd3, 1);
        add(1, 1, 2'd0, 4'hA, 4'h6, 4'hD, 4'h1, 4'h0, 0, 2'd0, 0);  // reset mid-stream
        add(0, 1, 2'd0, 4'h0, 4'h6, 4'hD, 4'h1, 4'h0, 1, 2'd0, 1);  // zero still pulses
        add(0, 0, 2'd2, 4'h0, 4'h6, 4'hD, 4'h1, 4'h0, 1, 2'd0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst    = vecs[i].rst;
            if4.en = vecs[i].en; if4.S = vecs[i].s;
            if4.A  = vecs[i].a;  if4.B = vecs[i].b;
            if4.C  = vecs[i].c;  if4.D = vecs[i].d;
            @(posedge clk);
            #1;
            chk("vec.Y",         64'(if4.Y),         64'(vecs[i].exp_y));
            chk("vec.Y_valid",   64'(if4.Y_valid),   64'(vecs[i].exp_v));
            chk("vec.S_q",       64'(if4.S_q),       64'(vecs[i].exp_s));
            chk("vec.Y_changed", 64'(if4.Y_changed), 64'(vecs[i].exp_c));
            $display("vec %0d rst=%0b en=%0b S=%0d Y=%h v=%0b S_q=%0d chg=%0b",
                     i, vecs[i].rst, vecs[i].en, vecs[i].s, if4.Y, if4.Y_valid,
                     if4.S_q, if4.Y_changed);
        end

        // Model starts from a clean reset for all instances
        for (int k = 0; k < 3; k++) begin
            en_v[k] = 1'b0; s_v[k] = 2'b00;
            for (int j = 0; j < 4; j++) din[k][j] = '0;
        end
        apply_all(1'b1, 0);

        // Width corner: n=16 with A=A5A5, D=0F0F, S=11; n=1 selecting D=1
        din[1][0] = 64'hA5A5; din[1][3] = 64'h0F0F; en_v[1] = 1'b1; s_v[1] = 2'd3;
        din[2][0] = 64'h0;    din[2][3] = 64'h1;    en_v[2] = 1'b1; s_v[2] = 2'd3;
        apply_all(1'b0, 1);
        chk("width.n16.Y", 64'(if16.Y), 64'h0F0F);
        chk("width.n1.Y",  64'(if1.Y),  64'h1);

        for (int t = 0; t < 300; t++) begin
            for (int k = 0; k < 3; k++) begin
                en_v[k] = ($urandom_range(0, 2) != 0);
                s_v[k]  = 2'($urandom_range(0, 3));
                // Bias data toward repeats so the no-change path is exercised
                for (int j = 0; j < 4; j++)
                    if ($urandom_range(0, 3) == 0)
                        din[k][j] = {$urandom, $urandom} & masks[k];
            end
            apply_all(($urandom_range(0, 24) == 0), t + 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mux_4x1_nbit.md
Name: mux_4x1_nbit

Overview:
- Parameterised n-bit, 4-input multiplexer with a registered output stage.
- S selects one of A/B/C/D; the selected word is captured into Y on the clock edge when `en` is high.
- Used as a generic datapath word selector wherever a one-cycle-latency, reset-clean select is needed.
- Also provides a valid flag, the latched select code, and a change-detect pulse for downstream monitoring.

Parameters:
- n, 4, data width in bits of A, B, C, D and Y; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous reset, active-high.
- en  input  1  capture strobe; when 1, the selected input is registered on this edge.
- A  input  n  data input, selected when S=2'b00.
- B  input  n  data input, selected when S=2'b01.
- C  input  n  data input, selected when S=2'b10.
- D  input  n  data input, selected when S=2'b11.
- S  input  2  select code.
- Y  output  n  registered selected data.
- Y_valid  output  1  high once Y holds a captured value since the last reset.
- S_q  output  2  select code captured alongside Y.
- Y_changed  output  1  one-cycle pulse when a capture produced a Y different from the previous Y.

Behaviour:
- Reset (rst=1 at a rising clk edge): Y=0, Y_valid=0, S_q=2'b00, Y_changed=0.
  - rst has priority over en.
  - Reset mid-stream discards any capture on that edge.
- Select decode is purely combinational inside the block: sel = (S==00)?A : (S==01)?B : (S==10)?C : D.
  - All four codes are defined; there is no X/default hole.
- Capture (rst=0, en=1 at a rising edge):
  - Y <= sel
  - S_q <= S
  - Y_valid <= 1
  - Y_changed <= (sel != Y) || (Y_valid == 0)
- Hold (rst=0, en=0):
  - Y, S_q and Y_valid keep their values.
  - Y_changed <= 0.
- Latency: exactly one clock from S/data present with en=1 to Y updated.
- Inputs are sampled only at the edge; glitches between edges have no effect.
- Y_changed is 1 for exactly one cycle per qualifying capture.
  - Back-to-back captures of identical values produce no pulse after the first valid capture.
  - The first capture after reset always pulses, even if the value is 0.
- Changing S while en=0 does not alter Y or S_q.
- Width rules:
  - No arithmetic; bit-exact copy of the selected input.
  - n=1 must work; all ports scale with n.
- The simultaneous change of S and data in the same cycle as en=1 uses the values present at that edge.

Test Plan:
- Reset: hold rst=1 for 2 cycles with A=4'b1010 and en=1 -> Y=0, Y_valid=0, S_q=0, Y_changed=0.
- Select sweep (n=4): A=4'b1010, B=4'b0110, C=4'b1101, D=4'b0001, en=1; S=00,01,10,11 on successive cycles -> Y one cycle later = 1010, 0110, 1101, 0001; S_q tracks S; Y_changed=1 on each.
- Hold: after Y=4'b1101 (S=10), drop en and change S to 11 and C to 4'b0000 for 3 cycles -> Y stays 1101, S_q=10, Y_changed=0.
- No-change capture: en=1, S=01, B=4'b0110 for 3 cycles -> Y=0110; Y_changed pulses only on the first of those captures (if the prior Y differed), then stays 0.
- Reset mid-stream: Y=4'b0001, Y_valid=1; assert rst with en=1, S=00 -> next cycle Y=0, Y_valid=0; on the first capture after release, Y_changed=1.
- Width: instantiate with n=1 and n=16, with A=16'hA5A5 and D=16'h0F0F; S=11 -> Y=16'h0F0F after one edge.
